tt_scanner: RTL and testbench

Sequential truth-table capture and check engine for the combinational exercise circuits. On `start` it sweeps every input code of a device under test from 0 to 2^N_IN−1 and holds each code for a settle window. It samples the single-bit response into a table and compares it against an expected table, reporting the mismatch count and the first failing code. It drives the input side of a circuit such as the 3-input question-4 function and reads its output, so it sits at the opposite end of the same ports.

---
 rtl/tt_scanner_pkg.sv | 21 ++
 rtl/tt_scanner_if.sv | 28 ++
 rtl/tt_scanner.sv | 100 ++++++++++
 tb/tb_tt_scanner.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tt_scanner_pkg.sv
// Shared types and defaults for the truth-table scanner: FSM states,
// default geometry, and the hold-counter width helper.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int TT_N_IN   = 3;
  localparam int TT_SETTLE = 2;

  // Counter must be able to hold the value SETTLE itself.
  function automatic int hold_cnt_w(input int settle);
    int w;
    w = $clog2(settle + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tt_scanner_if.sv
// Scanner bus: control/result handshake plus the stimulus/response pair
// that connects to the combinational circuit under test.
interface tt_scanner_if #(
  parameter int N_IN = 3
);
  logic                 start;
  logic [2**N_IN-1:0]   expected;
  logic [N_IN-1:0]      stim;
  logic                 resp;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   tbl;
  logic [N_IN:0]        mismatch_cnt;
  logic [N_IN-1:0]      first_fail;
  logic                 first_fail_valid;

  // Controller / environment side.
  modport master (
    output start, expected, resp,
    input  stim, busy, done, tbl, mismatch_cnt, first_fail, first_fail_valid
  );

  // Scanner side.
  modport slave (
    input  start, expected, resp,
    output stim, busy, done, tbl, mismatch_cnt, first_fail, first_fail_valid
  );
endinterface

// File: rtl/tt_scanner.sv
// Sweeps every input code, holds each for SETTLE+1 cycles, captures the
// single-bit response into a table and checks it against the expected table.
module tt_scanner
  import tt_pkg::*;
#(
  parameter int N_IN   = TT_N_IN,
  parameter int SETTLE = TT_SETTLE
) (
  input  logic        clk,
  input  logic        reset,
  tt_scanner_if.slave bus
);

  localparam int W  = 2**N_IN;
  localparam int CW = hold_cnt_w(SETTLE);
  localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};
  localparam logic [CW-1:0]   CNT_LAST  = CW'(SETTLE);

  state_t            r_state;
  logic [N_IN-1:0]   r_stim;
  logic [CW-1:0]     r_cnt;
  logic [W-1:0]      r_exp;
  logic [W-1:0]      r_tbl;
  logic [N_IN:0]     r_mcnt;
  logic [N_IN-1:0]   r_ff;
  logic              r_ffv;
  logic              r_busy;
  logic              r_done;
  logic              w_miss;

  assign w_miss = (bus.resp != r_exp[r_stim]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_stim  <= '0;
      r_cnt   <= '0;
      r_exp   <= '0;
      r_tbl   <= '0;
      r_mcnt  <= '0;
      r_ff    <= '0;
      r_ffv   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_exp   <= bus.expected;
            r_tbl   <= '0;
            r_mcnt  <= '0;
            r_ff    <= '0;
            r_ffv   <= 1'b0;
            r_stim  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (r_cnt == CNT_LAST) begin
            r_tbl[r_stim] <= bus.resp;
            if (w_miss) begin
              r_mcnt <= r_mcnt + 1'b1;
              // Only the lowest failing code is kept.
              if (!r_ffv) begin
                r_ff  <= r_stim;
                r_ffv <= 1'b1;
              end
            end
            if (r_stim != STIM_LAST) begin
              r_stim <= r_stim + 1'b1;
              r_cnt  <= '0;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.stim             = r_stim;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.tbl              = r_tbl;
  assign bus.mismatch_cnt     = r_mcnt;
  assign bus.first_fail       = r_ff;
  assign bus.first_fail_valid = r_ffv;

endmodule

// File: tb/tb_tt_scanner.sv
// Directed bench for tt_scanner: table-driven scans on a SETTLE=2 and a
// SETTLE=1 instance, plus restart-ignore and mid-scan reset sequences.
module tb_tt_scanner;

  logic clk;
  logic reset;
  int   mode;   // 0: sc4_func, 1: resp tied 1, 2: resp = stim[0]
  int   sel;    // 0: SETTLE=2 instance, 1: SETTLE=1 instance
  int   n_tests;
  int   n_fail;

  tt_scanner_if #(.N_IN(3)) b0 ();
  tt_scanner_if #(.N_IN(3)) b1 ();

  tt_scanner #(.N_IN(3), .SETTLE(2)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  tt_scanner #(.N_IN(3), .SETTLE(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Question-4 function with stim = {A1, A0, B}.
  function automatic logic sc4_func(input logic [2:0] s);
    logic a1, a0, b, acc;
    logic [15:0] x;
    a1 = s[2]; a0 = s[1]; b = s[0];
    x[0] = ~(a1 & a0);
    for (int i = 1; i <= 14; i++)
      x[i] = (i % 2 == 1) ? ~(x[i-1] ^ b) : (x[i-1] ^ b);
    x[15] = ~(x[14] | b);
    acc = |x;
    return ~acc;
  endfunction

  function automatic logic resp_of(input int m, input logic [2:0] s);
    case (m)
      0:       return sc4_func(s);
      1:       return 1'b1;
      default: return s[0];
    endcase
  endfunction

  assign b0.resp = resp_of(mode, b0.stim);
  assign b1.resp = resp_of(mode, b1.stim);

  logic       m_done, m_busy, m_ffv;
  logic [7:0] m_tbl;
  logic [3:0] m_cnt;
  logic [2:0] m_ff, m_stim;

  always_comb begin
    m_done = b0.done; m_busy = b0.busy; m_ffv = b0.first_fail_valid;
    m_tbl  = b0.tbl;  m_cnt  = b0.mismatch_cnt; m_ff = b0.first_fail; m_stim = b0.stim;
    if (sel == 1) begin
      m_done = b1.done; m_busy = b1.busy; m_ffv = b1.first_fail_valid;
      m_tbl  = b1.tbl;  m_cnt  = b1.mismatch_cnt; m_ff = b1.first_fail; m_stim = b1.stim;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) b0.start = v; else b1.start = v;
  endtask

  // Accept a scan, then count edges after acceptance until done (bounded).
  task automatic run_scan(input logic [7:0] exp_in, input int settle,
                          input bit chk_stim, output int lat);
    int n;
    @(negedge clk);
    b0.expected = exp_in;
    b1.expected = exp_in;
    set_start(1'b1);
    @(posedge clk);              // acceptance edge E0
    @(negedge clk);
    set_start(1'b0);
    chk("busy_after_accept", int'(m_busy), 1);
    n = 0;
    while (!m_done && n < 100) begin
      if (chk_stim) chk($sformatf("stim_seq_%0d", n), int'(m_stim), n / (settle + 1));
      @(negedge clk);
      n++;
    end
    lat = n;
  endtask

  typedef struct {
    int         dut;
    int         md;
    logic [7:0] exp_in;
    logic [7:0] tbl;
    int         cnt;
    int         ffv;
    int         ff;
    int         lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat, pulses, first_done;
    n_tests = 0; n_fail = 0;
    mode = 0; sel = 0;
    b0.start = 1'b0; b1.start = 1'b0;
    b0.expected = '0; b1.expected = '0;

    vecs[0] = '{0, 0, 8'h00, 8'h00, 0, 0, 0, 24};
    vecs[1] = '{0, 0, 8'h28, 8'h00, 2, 1, 3, 24};
    vecs[2] = '{0, 1, 8'h00, 8'hFF, 8, 1, 0, 24};
    vecs[3] = '{1, 2, 8'hAA, 8'hAA, 0, 0, 0, 16};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(b0.busy), 0);
    chk("rst_done", int'(b0.done), 0);
    chk("rst_stim", int'(b0.stim), 0);
    chk("rst_tbl",  int'(b0.tbl), 0);
    chk("rst_cnt",  int'(b0.mismatch_cnt), 0);
    chk("rst_ffv",  int'(b0.first_fail_valid), 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      sel  = vecs[i].dut;
      mode = vecs[i].md;
      run_scan(vecs[i].exp_in, (sel == 1) ? 1 : 2, (i == 3), lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_tbl", i), int'(m_tbl), int'(vecs[i].tbl));
      chk($sformatf("v%0d_cnt", i), int'(m_cnt), vecs[i].cnt);
      chk($sformatf("v%0d_ffv", i), int'(m_ffv), vecs[i].ffv);
      if (vecs[i].ffv != 0) chk($sformatf("v%0d_ff", i), int'(m_ff), vecs[i].ff);
      chk($sformatf("v%0d_busy_at_done", i), int'(m_busy), 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), int'(m_done), 0);
      chk($sformatf("v%0d_stim_hold", i), int'(m_stim), 7);
      chk($sformatf("v%0d_tbl_hold", i), int'(m_tbl), int'(vecs[i].tbl));
    end

    // Second start 5 cycles into a scan must be ignored.
    sel = 0; mode = 0;
    @(negedge clk);
    b0.expected = 8'h00;
    b0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b0.start = 1'b0;
    pulses = 0; first_done = -1;
    for (int n = 0; n <= 30; n++) begin
      if (n == 5) b0.start = 1'b1;
      if (n == 6) b0.start = 1'b0;
      if (b0.done) begin
        pulses++;
        if (first_done < 0) first_done = n;
      end
      @(negedge clk);
    end
    chk("restart_done_cycle", first_done, 24);
    chk("restart_pulses", pulses, 1);
    chk("restart_cnt", int'(b0.mismatch_cnt), 0);

    // Asynchronous reset mid-scan, then a clean full scan.
    mode = 1;
    @(negedge clk);
    b0.expected = 8'h00;
    b0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b0.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_tbl", int'(b0.tbl), 8'h07);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", int'(b0.busy), 0);
    chk("midrst_stim", int'(b0.stim), 0);
    chk("midrst_tbl",  int'(b0.tbl), 0);
    chk("midrst_cnt",  int'(b0.mismatch_cnt), 0);
    chk("midrst_ffv",  int'(b0.first_fail_valid), 0);
    chk("midrst_done", int'(b0.done), 0);
    @(negedge clk);
    reset = 1'b0;
    mode = 0;
    run_scan(8'h28, 2, 1'b0, lat);
    chk("postrst_latency", lat, 24);
    chk("postrst_cnt", int'(b0.mismatch_cnt), 2);
    chk("postrst_ff",  int'(b0.first_fail), 3);
    chk("postrst_ffv", int'(b0.first_fail_valid), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
